// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line idle level and default frame shape.
// The PARITY state and parity helper exist only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int   DEFAULT_DATA_BITS = 8;
    localparam int   DEFAULT_STOP_BITS = 1;
    localparam logic IDLE_LEVEL        = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd5
    } state_e;

`ifdef UART_TX_PARITY_EN
    // Payloads narrower than 8 bits are zero-extended, which leaves even parity unchanged.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one frame per accepted word, bit timing driven by an external baud_tick.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int STOP_BITS = DEFAULT_STOP_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_done
);

    localparam int               CNT_W     = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    state_e               r_state;
    state_e               w_next_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_tx;
    logic                 r_ready;
    logic                 w_tx_next;
    logic                 w_done;
    logic                 w_accept;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    assign w_accept = (r_state == IDLE) && r_ready && tx_valid;
    assign tx       = r_tx;
    assign tx_ready = r_ready;
    assign tx_done  = w_done;

    // Next-state and next line level; tx changes only on ticks so each bit spans one tick period.
    always_comb begin
        w_next_state = r_state;
        w_tx_next    = r_tx;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_next = IDLE_LEVEL;
                if (w_accept) begin
                    w_next_state = SYNC;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SYNC: begin
                if (baud_tick) begin
                    w_next_state = START;
                    w_tx_next    = 1'b0;
                end else begin
                    w_tx_next    = IDLE_LEVEL;
                end
            end
            START: begin
                if (baud_tick) begin
                    w_next_state = DATA;
                    w_tx_next    = r_shift[0];
                end else begin
                    w_next_state = START;
                end
            end
            DATA: begin
                if (baud_tick && (r_bit_cnt == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
                    w_next_state = PARITY;
                    w_tx_next    = r_parity;
`else
                    w_next_state = STOP;
                    w_tx_next    = IDLE_LEVEL;
`endif
                end else if (baud_tick) begin
                    w_tx_next    = r_shift[0];
                end else begin
                    w_next_state = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    w_next_state = STOP;
                    w_tx_next    = IDLE_LEVEL;
                end else begin
                    w_next_state = PARITY;
                end
            end
`endif
            STOP: begin
                w_tx_next = IDLE_LEVEL;
                if (baud_tick && (r_stop_cnt == LAST_STOP)) begin
                    w_next_state = IDLE;
                    w_done       = 1'b1;
                end else begin
                    w_next_state = STOP;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_tx_next    = IDLE_LEVEL;
            end
        endcase
    end

    // State, line and ready registers; ready is high exactly while the FSM sits in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_tx    <= IDLE_LEVEL;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_tx    <= w_tx_next;
            r_ready <= (w_next_state == IDLE);
        end
    end

    // Payload shift register and bit/stop counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_shift  <= tx_data;
`ifdef UART_TX_PARITY_EN
                r_parity <= even_parity(8'(tx_data));
`endif
            end else if (baud_tick && ((r_state == START) || (r_state == DATA))) begin
                r_shift <= r_shift >> 1;
            end
            if (baud_tick && (r_state == START)) begin
                r_bit_cnt <= '0;
            end else if (baud_tick && (r_state == DATA)) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (r_state != STOP) begin
                r_stop_cnt <= 1'b0;
            end else if (baud_tick) begin
                r_stop_cnt <= r_stop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001 SHALL have parameter DATA_BITS, default 8: payload width, legal 5..8.
- REQ-002 SHALL have parameter STOP_BITS, default 1: stop-bit count, legal 1 or 2.
- REQ-003 SHALL have port clk, input, 1: single clock for all logic.
- REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
- REQ-005 SHALL have port baud_tick, input, 1: one-clk pulse per bit period, from baud_gen.
- REQ-006 SHALL have port tx_valid, input, 1: tx_data holds a byte to send.
- REQ-007 SHALL have port tx_data, input, DATA_BITS: payload.
- REQ-008 SHALL have port tx_ready, output, 1: block can accept a byte.
- REQ-009 SHALL have port tx, output, 1: serial line, idle high.
- REQ-010 SHALL have port tx_done, output, 1: one-clk pulse at frame end.

Function
- REQ-011 SHALL implement FSM states IDLE, SYNC, START, DATA, PARITY, STOP.
- REQ-012 SHALL assert tx_ready only in IDLE; a transfer is accepted on a clk edge with tx_valid=1 and tx_ready=1.
- REQ-013 SHALL latch tx_data into a shift register on acceptance and move to SYNC; later tx_data/tx_valid changes have no effect on the frame.
- REQ-014 SHALL, in SYNC, wait for the next baud_tick after the acceptance cycle; a tick coincident with acceptance SHALL be ignored.
- REQ-015 SHALL, on the SYNC-ending tick, enter START and drive tx=0 from the following cycle, so every bit lasts exactly one tick period.
- REQ-016 SHALL advance one bit per baud_tick: START -> DATA (DATA_BITS bits, LSB first) -> PARITY (if enabled) -> STOP (STOP_BITS high bits) -> IDLE.
- REQ-017 SHALL register tx (no combinational path from inputs to tx).
- REQ-018 SHALL pulse tx_done for one cycle on the tick that ends the last stop bit, same cycle as the STOP->IDLE transition; tx_ready rises on the next cycle.
- REQ-019 SHALL count data bits with a counter of width clog2(DATA_BITS)+1 that clears on entry to DATA; no wrap occurs within a frame.
- REQ-020 SHALL hold tx=1 in IDLE and SYNC; baud_tick in IDLE has no effect.
- REQ-021 SHALL ignore tx_valid outside IDLE (no queuing, no error).

Reset
- REQ-022 SHALL, while rst=1, force state IDLE, tx=1, tx_ready=0, tx_done=0, counters and shift register 0, asynchronously.
- REQ-023 SHALL abandon any in-flight frame on reset; tx_ready=1 on the first clk edge after rst deasserts.

Configuration
- REQ-024 SHALL compile the PARITY state in only when macro UART_TX_PARITY_EN is defined; then one even-parity bit (XOR of the data bits) is sent between the last data bit and stop.
- REQ-025 SHALL, without UART_TX_PARITY_EN, go DATA -> STOP directly, with no parity logic synthesized.

Structure
- REQ-026 SHALL take the state enum typedef, IDLE_LEVEL=1 and the default DATA_BITS/STOP_BITS constants from shared package uart_pkg.
- REQ-027 SHALL contain no sub-module; baud_tick comes from a baud_gen instance at the UART top level, not inside uart_tx.

Verification (bench: baud_tick every 16 clk)
- REQ-028 SHALL check 0xA5, no parity: tx low 16 clk, then 1,0,1,0,0,1,0,1 at 16 clk each, then high 16 clk; tx_done pulses once; tx_ready low throughout.
- REQ-029 SHALL check 0xA5 with UART_TX_PARITY_EN: parity bit 0 after bit 7; 0x07 gives parity bit 1.
- REQ-030 SHALL check acceptance coincident with baud_tick: start bit begins after the following tick, 16 clk later, not immediately.
- REQ-031 SHALL check tx_data changed to 0x3C mid-frame with tx_valid held: 0xA5 is still sent; 0x3C is accepted only after tx_ready returns.
- REQ-032 SHALL check rst pulsed during data bit 3: tx=1 at once, no tx_done; a new 0x55 frame is then sent correctly.
- REQ-033 SHALL check STOP_BITS=2: stop high 32 clk, tx_done at its end.
